// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream bundle with a per-beat drop flag, LANES streams wide.
// Signals: tvalid/tready/tlast/drop (LANES bits), tdata (LANES*BYTES*8),
// tuser (LANES*USER_BITS); lane k occupies slice k of each vector.
// master drives the payload and samples tready; slave is the reverse.
interface axis_packet_arbiter_if #(
  parameter int unsigned LANES     = 1,
  parameter int unsigned BYTES     = 1,
  parameter int unsigned USER_BITS = 1
);
  logic [LANES-1:0]           tvalid;
  logic [LANES-1:0]           tready;
  logic [LANES-1:0]           tlast;
  logic [LANES-1:0]           drop;
  logic [LANES*BYTES*8-1:0]   tdata;
  logic [LANES*USER_BITS-1:0] tuser;

  modport master (output tvalid, tlast, tdata, tuser, drop, input tready);
  modport slave  (input tvalid, tlast, tdata, tuser, drop, output tready);
endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter merging N AXI-Stream sources into one
// drop-capable packet FIFO. A grant is held from first beat to tlast; a stall
// watchdog closes a silent packet with a dropped tlast beat, then drains the
// rest of that packet from its source.
// Ports:
//   clk, aresetn   - clock, asynchronous active-low reset
//   axis_i         - N upstream lanes (slave side)
//   axis_o         - merged stream to the FIFO (master side)
//   o_grant        - one-hot granted source, zero when idle
//   o_abort        - pulses on the handshake of the abort beat
//   o_abort_count  - saturating count of aborted packets
module axis_packet_arbiter #(
  parameter int unsigned N              = 2,
  parameter int unsigned AXIS_BYTES     = 1,
  parameter int unsigned AXIS_USER_BITS = 1,
  parameter int unsigned TIMEOUT        = 1024
) (
  input  logic                   clk,
  input  logic                   aresetn,
  axis_packet_arbiter_if.slave   axis_i,
  axis_packet_arbiter_if.master  axis_o,
  output logic [N-1:0]           o_grant,
  output logic                   o_abort,
  output logic [15:0]            o_abort_count
);

  localparam int unsigned DW = AXIS_BYTES * 8;
  localparam int unsigned UW = AXIS_USER_BITS;
  localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] STALL_LIMIT = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS  = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [GW-1:0] g, g_nxt;
  logic [GW-1:0] last, last_nxt;
  logic [CW-1:0] stall_cnt, stall_nxt;
  logic [15:0]   abort_cnt, abort_nxt;

  logic          pick_valid;
  logic [GW-1:0] pick_idx;

  logic          sel_valid;
  logic          sel_last;
  logic          sel_drop;
  logic [DW-1:0] sel_data;
  logic [UW-1:0] sel_user;

  // Granted source's lane, selected by the registered grant index
  assign sel_valid = axis_i.tvalid[g];
  assign sel_last  = axis_i.tlast[g];
  assign sel_drop  = axis_i.drop[g];
  assign sel_data  = axis_i.tdata[32'(g) * DW +: DW];
  assign sel_user  = axis_i.tuser[32'(g) * UW +: UW];

  // Round-robin pick: first valid source after the last one served
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      if (!pick_valid && axis_i.tvalid[GW'((32'(last) + i) % N)]) begin
        pick_valid = 1'b1;
        pick_idx   = GW'((32'(last) + i) % N);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      g         <= '0;
      last      <= GW'(N - 1);
      stall_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      state     <= state_nxt;
      g         <= g_nxt;
      last      <= last_nxt;
      stall_cnt <= stall_nxt;
      abort_cnt <= abort_nxt;
    end
  end

  // Next-state and stream steering
  always_comb begin
    state_nxt     = state;
    g_nxt         = g;
    last_nxt      = last;
    stall_nxt     = '0;
    abort_nxt     = abort_cnt;
    axis_i.tready = '0;
    axis_o.tvalid = 1'b0;
    axis_o.tlast  = 1'b0;
    axis_o.drop   = 1'b0;
    axis_o.tdata  = '0;
    axis_o.tuser  = '0;
    o_grant       = '0;
    o_abort       = 1'b0;

    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          g_nxt     = pick_idx;
          state_nxt = S_PASS;
        end
      end

      S_PASS: begin
        o_grant[g]       = 1'b1;
        axis_o.tvalid    = sel_valid;
        axis_o.tlast     = sel_last;
        axis_o.drop      = sel_drop;
        axis_o.tdata     = sel_data;
        axis_o.tuser     = sel_user;
        axis_i.tready[g] = axis_o.tready;
        if (sel_valid && axis_o.tready && sel_last) begin
          last_nxt  = g;
          state_nxt = S_IDLE;
        end else if (!sel_valid && (TIMEOUT != 0)) begin
          // Only source silence counts; downstream backpressure keeps valid high
          stall_nxt = stall_cnt + CW'(1);
          if (stall_nxt == STALL_LIMIT) begin
            state_nxt = S_ABORT;
          end
        end
      end

      S_ABORT: begin
        // Close the packet downstream with an empty dropped tlast beat
        o_grant[g]    = 1'b1;
        axis_o.tvalid = 1'b1;
        axis_o.tlast  = 1'b1;
        axis_o.drop   = 1'b1;
        if (axis_o.tready) begin
          o_abort   = 1'b1;
          state_nxt = S_DRAIN;
          if (abort_cnt != 16'hFFFF) begin
            abort_nxt = abort_cnt + 16'd1;
          end
        end
      end

      S_DRAIN: begin
        // Swallow the remainder of the aborted packet
        o_grant[g]       = 1'b1;
        axis_i.tready[g] = 1'b1;
        if (sel_valid && sel_last) begin
          last_nxt  = g;
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_abort_count = abort_cnt;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
module tb_axis_packet_arbiter;

  localparam int unsigned NA  = 4;
  localparam int unsigned BA  = 2;
  localparam int unsigned UA  = 2;
  localparam int unsigned TA  = 8;
  localparam int unsigned DWA = BA * 8;
  localparam int unsigned NB  = 2;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  user;
    logic        last;
    logic        drop;
  } beat_t;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  axis_packet_arbiter_if #(.LANES(NA), .BYTES(BA), .USER_BITS(UA)) ia_i ();
  axis_packet_arbiter_if #(.LANES(1),  .BYTES(BA), .USER_BITS(UA)) ia_o ();
  axis_packet_arbiter_if #(.LANES(NB), .BYTES(1),  .USER_BITS(1))  ib_i ();
  axis_packet_arbiter_if #(.LANES(1),  .BYTES(1),  .USER_BITS(1))  ib_o ();

  logic [NA-1:0] grant_a;
  logic          abort_a;
  logic [15:0]   abort_cnt_a;
  logic [NB-1:0] grant_b;
  logic          abort_b;
  logic [15:0]   abort_cnt_b;

  axis_packet_arbiter #(.N(NA), .AXIS_BYTES(BA), .AXIS_USER_BITS(UA), .TIMEOUT(TA)) dut_a (
    .clk(clk), .aresetn(aresetn), .axis_i(ia_i), .axis_o(ia_o),
    .o_grant(grant_a), .o_abort(abort_a), .o_abort_count(abort_cnt_a)
  );

  axis_packet_arbiter #(.N(NB), .AXIS_BYTES(1), .AXIS_USER_BITS(1), .TIMEOUT(0)) dut_b (
    .clk(clk), .aresetn(aresetn), .axis_i(ib_i), .axis_o(ib_o),
    .o_grant(grant_b), .o_abort(abort_b), .o_abort_count(abort_cnt_b)
  );

  // Source model for dut_a: per-source beat memory with an optional silent gap
  beat_t mem [NA][64];
  int    wr [NA];
  int    rd [NA];
  int    gap_at [NA];
  int    gap_len [NA];
  int    gap_cnt [NA];

  beat_t exp_q[$];
  int    exp_src_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;
  int abort_pulses = 0;
  int last_hs_cyc = 0;
  int prev_hs_cyc = 0;
  bit chk_gap = 1'b0;
  bit in_pkt = 1'b0;
  int prev_first_cyc = -1;
  int prev_len = 0;
  int cur_len = 0;
  logic        obs_valid;
  logic        obs_last;
  logic [15:0] obs_data;

  function automatic beat_t make_beat(input int k, input int pkt, input int b,
                                      input int n, input int drop_b);
    beat_t x;
    x.data = 16'((k << 12) | (pkt << 4) | b);
    x.user = 2'(b);
    x.last = (b == n - 1);
    x.drop = (b == drop_b);
    return x;
  endfunction

  task automatic load_pkt(input int k, input int pkt, input int n, input int drop_b);
    for (int b = 0; b < n; b++) begin
      mem[k][wr[k]] = make_beat(k, pkt, b, n, drop_b);
      wr[k]++;
    end
  endtask

  task automatic expect_pkt(input int k, input int pkt, input int n, input int drop_b,
                            input int first_b, input int cnt);
    for (int b = first_b; b < first_b + cnt; b++) begin
      exp_q.push_back(make_beat(k, pkt, b, n, drop_b));
      exp_src_q.push_back(k);
    end
  endtask

  function automatic bit sources_empty();
    for (int k = 0; k < NA; k++) if (rd[k] != wr[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    beat_t x;
    for (int k = 0; k < NA; k++) begin
      if (rd[k] != wr[k] && gap_cnt[k] == 0) begin
        x = mem[k][rd[k]];
        ia_i.tvalid[k] = 1'b1;
        ia_i.tlast[k]  = x.last;
        ia_i.drop[k]   = x.drop;
        ia_i.tdata[k*DWA +: DWA] = x.data;
        ia_i.tuser[k*UA +: UA]   = x.user;
      end else begin
        ia_i.tvalid[k] = 1'b0;
        ia_i.tlast[k]  = 1'b0;
        ia_i.drop[k]   = 1'b0;
        ia_i.tdata[k*DWA +: DWA] = '0;
        ia_i.tuser[k*UA +: UA]   = '0;
      end
    end
  endtask

  // One clock of dut_a: scoreboard at negedge, source advance after posedge
  task automatic step();
    bit    acc [NA];
    beat_t got;
    beat_t exp;
    int    src;
    @(negedge clk);
    obs_valid = ia_o.tvalid;
    obs_last  = ia_o.tlast;
    obs_data  = ia_o.tdata;
    if (abort_a) abort_pulses++;
    if (ia_o.tvalid && ia_o.tready) begin
      hs_count++;
      prev_hs_cyc = last_hs_cyc;
      last_hs_cyc = cyc;
      got = {ia_o.tdata, ia_o.tuser, ia_o.tlast, ia_o.drop};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got %h, required no beat", got);
      end else begin
        exp = exp_q.pop_front();
        src = exp_src_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL beat: got %h, required %h", got, exp);
        end
        checks++;
        if (grant_a !== 4'(1 << src)) begin
          errors++;
          $display("FAIL grant: got %b, required %b", grant_a, 4'(1 << src));
        end
      end
      if (!in_pkt) begin
        if (chk_gap && prev_first_cyc >= 0) begin
          checks++;
          if (cyc - prev_first_cyc != prev_len + 1) begin
            errors++;
            $display("FAIL packet_spacing: got %0d cycles, required %0d",
                     cyc - prev_first_cyc, prev_len + 1);
          end
        end
        prev_first_cyc = cyc;
        cur_len = 0;
        in_pkt = 1'b1;
      end
      cur_len++;
      if (ia_o.tlast) begin
        in_pkt = 1'b0;
        prev_len = cur_len;
      end
    end
    for (int k = 0; k < NA; k++) acc[k] = ia_i.tvalid[k] && ia_i.tready[k];
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NA; k++) begin
      if (gap_cnt[k] > 0) gap_cnt[k]--;
      if (acc[k]) begin
        rd[k]++;
        if (rd[k] == gap_at[k]) gap_cnt[k] = gap_len[k];
      end
    end
    drive();
  endtask

  task automatic run_until_done(input int max_cycles, input string name);
    int n = 0;
    while ((!sources_empty() || exp_q.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (!sources_empty() || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d beats still expected after %0d cycles, required 0",
               name, exp_q.size(), n);
    end
  endtask

  task automatic new_test(input bit gap);
    chk_gap = gap;
    in_pkt = 1'b0;
    prev_first_cyc = -1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    ia_o.tready = 1'b1;
    ib_o.tready = 1'b1;
    #3;
    checks++;
    if ({grant_a, abort_a, abort_cnt_a, ia_i.tready, ia_o.tvalid, ia_o.tlast,
         ia_o.drop, ia_o.tdata, ia_o.tuser} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_a: got grant=%b tready=%b tvalid=%b cnt=%0d, required all 0",
               grant_a, ia_i.tready, ia_o.tvalid, abort_cnt_a);
    end
    checks++;
    if ({grant_b, abort_b, abort_cnt_b, ib_i.tready, ib_o.tvalid, ib_o.tlast,
         ib_o.drop, ib_o.tdata, ib_o.tuser} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b: got grant=%b tready=%b tvalid=%b, required all 0",
               grant_b, ib_i.tready, ib_o.tvalid);
    end
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    repeat (5) step();
    checks++;
    if ({grant_a, ia_o.tvalid, ia_i.tready} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got grant=%b tvalid=%b tready=%b, required 0",
               grant_a, ia_o.tvalid, ia_i.tready);
    end
    // Stall a packet mid-PASS with backpressure, then reset under it
    ia_o.tready = 1'b0;
    load_pkt(0, 9, 3, -1);
    drive();
    repeat (3) step();
    checks++;
    if (grant_a !== 4'b0001 || ia_o.tvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pass_grant: got grant=%b tvalid=%b, required 0001 1",
               grant_a, ia_o.tvalid);
    end
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({grant_a, abort_a, abort_cnt_a, ia_i.tready, ia_o.tvalid, ia_o.tlast,
         ia_o.drop, ia_o.tdata, ia_o.tuser} !== '0) begin
      errors++;
      $display("FAIL reset_mid_pass: got grant=%b tready=%b tvalid=%b data=%h, required all 0",
               grant_a, ia_i.tready, ia_o.tvalid, ia_o.tdata);
    end
    for (int k = 0; k < NA; k++) rd[k] = wr[k];
    drive();
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    ia_o.tready = 1'b1;
    repeat (3) step();
    checks++;
    if ({grant_a, ia_o.tvalid, ia_i.tready} !== '0) begin
      errors++;
      $display("FAIL idle_after_release: got grant=%b tvalid=%b tready=%b, required 0",
               grant_a, ia_o.tvalid, ia_i.tready);
    end
  endtask

  task automatic test_round_robin();
    new_test(1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < NA; k++) begin
        load_pkt(k, p, 3, -1);
        expect_pkt(k, p, 3, -1, 0, 3);
      end
    end
    drive();
    run_until_done(200, "round_robin");
  endtask

  task automatic test_drop();
    new_test(1'b1);
    load_pkt(2, 1, 4, 2);
    expect_pkt(2, 1, 4, 2, 0, 4);
    drive();
    run_until_done(50, "drop");
  endtask

  task automatic test_back_to_back();
    new_test(1'b1);
    load_pkt(0, 4, 2, -1);
    load_pkt(0, 5, 2, -1);
    load_pkt(0, 6, 1, -1);
    expect_pkt(0, 4, 2, -1, 0, 2);
    expect_pkt(0, 5, 2, -1, 0, 2);
    expect_pkt(0, 6, 1, -1, 0, 1);
    drive();
    run_until_done(50, "back_to_back");
    checks++;
    if (grant_a !== '0 || ia_o.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_between_tests: got grant=%b tvalid=%b, required 0 0",
               grant_a, ia_o.tvalid);
    end
  endtask

  task automatic test_backpressure();
    int base = hs_count;
    int n = 0;
    int base_pulses = abort_pulses;
    logic [17:0] snap;
    new_test(1'b0);
    load_pkt(3, 2, 4, -1);
    expect_pkt(3, 2, 4, -1, 0, 4);
    drive();
    while (hs_count < base + 2 && n < 20) begin
      step();
      n++;
    end
    ia_o.tready = 1'b0;
    step();
    snap = {obs_valid, obs_last, obs_data};
    checks++;
    if (snap !== {1'b1, 1'b0, make_beat(3, 2, 2, 4, -1).data}) begin
      errors++;
      $display("FAIL stall_beat: got %h, required %h", snap,
               {1'b1, 1'b0, make_beat(3, 2, 2, 4, -1).data});
    end
    for (int i = 1; i < 50; i++) begin
      step();
      checks++;
      if ({obs_valid, obs_last, obs_data} !== snap) begin
        errors++;
        $display("FAIL stall_stable: cycle %0d got %h, required %h", i,
                 {obs_valid, obs_last, obs_data}, snap);
      end
    end
    checks++;
    if (abort_pulses != base_pulses || abort_cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL backpressure_abort: got pulses=%0d count=%0d, required 0 0",
               abort_pulses - base_pulses, abort_cnt_a);
    end
    ia_o.tready = 1'b1;
    run_until_done(50, "backpressure");
  endtask

  task automatic test_abort();
    beat_t ab;
    int n = 0;
    new_test(1'b0);
    abort_pulses = 0;
    gap_at[1] = rd[1] + 2;
    gap_len[1] = TA;
    load_pkt(1, 7, 5, -1);
    load_pkt(2, 8, 1, -1);
    expect_pkt(1, 7, 5, -1, 0, 2);
    ab = '{data: 16'h0000, user: 2'b00, last: 1'b1, drop: 1'b1};
    exp_q.push_back(ab);
    exp_src_q.push_back(1);
    expect_pkt(2, 8, 1, -1, 0, 1);
    drive();
    while (abort_pulses == 0 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (last_hs_cyc - prev_hs_cyc != TA + 1) begin
      errors++;
      $display("FAIL abort_timing: got %0d cycles after last beat, required %0d",
               last_hs_cyc - prev_hs_cyc, TA + 1);
    end
    run_until_done(100, "abort");
    gap_at[1] = -1;
    checks++;
    if (abort_pulses != 1) begin
      errors++;
      $display("FAIL abort_pulses: got %0d, required 1", abort_pulses);
    end
    checks++;
    if (abort_cnt_a !== 16'd1) begin
      errors++;
      $display("FAIL abort_count: got %0d, required 1", abort_cnt_a);
    end
  endtask

  task automatic test_no_watchdog();
    logic [7:0] exp_b[$];
    logic [7:0] e;
    int  phase = 0;
    int  stall = 0;
    int  n = 0;
    bit  acc;
    bit  abort_seen = 1'b0;
    bit  grant_lost = 1'b0;
    ib_i.tvalid = 2'b01;
    ib_i.tlast  = 2'b00;
    ib_i.tdata  = 16'h00A5;
    exp_b.push_back(8'hA5);
    while (phase != 3 && n < 10100) begin
      @(negedge clk);
      acc = ib_i.tvalid[0] && ib_i.tready[0];
      if (abort_b) abort_seen = 1'b1;
      if (phase == 1 && grant_b !== 2'b01) grant_lost = 1'b1;
      if (ib_o.tvalid && ib_o.tready) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected_beat: got %h, required no beat", ib_o.tdata);
        end else begin
          e = exp_b.pop_front();
          if (ib_o.tdata !== e) begin
            errors++;
            $display("FAIL b_beat: got %h, required %h", ib_o.tdata, e);
          end
        end
      end
      @(posedge clk);
      #1;
      n++;
      case (phase)
        0: if (acc) begin phase = 1; ib_i.tvalid = 2'b00; ib_i.tdata = '0; end
        1: begin
          stall++;
          if (stall == 10000) begin
            phase = 2;
            ib_i.tvalid = 2'b01;
            ib_i.tlast  = 2'b01;
            ib_i.tdata  = 16'h005A;
            exp_b.push_back(8'h5A);
          end
        end
        2: if (acc) begin
          phase = 3;
          ib_i.tvalid = 2'b00;
          ib_i.tlast  = 2'b00;
          ib_i.tdata  = '0;
        end
        default: ;
      endcase
    end
    checks++;
    if (phase != 3 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL b_complete: got phase=%0d pending=%0d, required 3 0", phase, exp_b.size());
    end
    checks++;
    if (abort_seen || abort_cnt_b !== 16'd0) begin
      errors++;
      $display("FAIL b_no_abort: got pulse=%b count=%0d, required 0 0", abort_seen, abort_cnt_b);
    end
    checks++;
    if (grant_lost) begin
      errors++;
      $display("FAIL b_grant_held: got grant lost during stall, required 01 held");
    end
    checks++;
    if (grant_b !== 2'b00) begin
      errors++;
      $display("FAIL b_idle: got grant=%b, required 00", grant_b);
    end
  endtask

  initial begin
    for (int k = 0; k < NA; k++) begin
      wr[k] = 0; rd[k] = 0; gap_at[k] = -1; gap_len[k] = 0; gap_cnt[k] = 0;
    end
    ia_i.tvalid = '0; ia_i.tlast = '0; ia_i.drop = '0; ia_i.tdata = '0; ia_i.tuser = '0;
    ib_i.tvalid = '0; ib_i.tlast = '0; ib_i.drop = '0; ib_i.tdata = '0; ib_i.tuser = '0;
    ia_o.tready = 1'b0;
    ib_o.tready = 1'b0;
    test_reset();
    test_round_robin();
    test_drop();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_no_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
